// File: rtl/io_stage_params.sv
// rtl/io_stage_params.sv - IO-to-WB pipeline bus as produced by the IO stage.
package io_stage_params;

    typedef struct packed {
        logic        valid;
        logic [31:0] program_count;
        logic [31:0] final_result;
        logic [4:0]  register_file_address;
        logic        register_file_write_enabled;
        logic [3:0]  register_file_write_strobe;
        logic [4:0]  cp0_address_register;
        logic [2:0]  cp0_address_select;
        logic        move_from_cp0;
        logic        move_to_cp0;
        logic        exception_valid;
        logic        in_delay_slot;
        logic        eret_flush;
        logic [4:0]  exception_code;
    } IOToWBData;

endpackage

// File: rtl/wb_stage_params.sv
// rtl/wb_stage_params.sv - WB stage buses, CP0 register map, exception codes and CP0 bit positions.
package wb_stage_params;

    typedef struct packed {
        logic        exception_valid;
        logic        eret_flush;
        logic [31:0] target;
    } WBExceptionBus;

    typedef struct packed {
        logic        valid;
        logic [4:0]  write_register;
        logic [3:0]  write_strobe;
        logic [31:0] write_data;
    } WBToIDBackPassData;

    typedef enum logic [4:0] {
        CP0_COUNT   = 5'd9,
        CP0_COMPARE = 5'd11,
        CP0_STATUS  = 5'd12,
        CP0_CAUSE   = 5'd13,
        CP0_EPC     = 5'd14
    } Cp0Register;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam int STATUS_IE     = 0;
    localparam int STATUS_EXL    = 1;
    localparam int STATUS_IM_LO  = 8;
    localparam int STATUS_BEV    = 22;
    localparam int CAUSE_EXC_LO  = 2;
    localparam int CAUSE_IP_LO   = 8;
    localparam int CAUSE_TI      = 30;
    localparam int CAUSE_BD      = 31;

    localparam logic [31:0] STATUS_WRITE_MASK = 32'h0000_ff03;
    localparam logic [31:0] CAUSE_WRITE_MASK  = 32'h0000_0300;

endpackage

// File: rtl/cp0_register_file.sv
// rtl/cp0_register_file.sv - CP0 Status/Cause/EPC/Count/Compare with exception, ERET and interrupt logic.
// Optional timer interrupt built when WB_TIMER_INTERRUPT_EN is defined.
module cp0_register_file
    import wb_stage_params::*;
#(
    parameter logic [31:0] RESET_STATUS = 32'h0040_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        wb_valid,
    input  logic        exception_valid,
    input  logic        eret_flush,
    input  logic        in_delay_slot,
    input  logic [4:0]  exception_code,
    input  logic [31:0] program_count,
    input  logic        move_to_cp0,
    input  logic [4:0]  cp0_address_register,
    input  logic [2:0]  cp0_address_select,
    input  logic [31:0] write_data,
    input  logic [5:0]  hardware_interrupt,
    output logic [31:0] read_data,
    output logic [31:0] epc,
    output logic        interrupt_pending
);

    logic [31:0] status_q, status_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        interrupt_pending_q, interrupt_pending_d;
    logic        cp0_write;
`ifdef WB_TIMER_INTERRUPT_EN
    logic        tick_q, tick_d;
    logic        compare_write;
    logic        ti_d;
`endif

    always_comb begin
        status_d  = status_q;
        cause_d   = cause_q;
        epc_d     = epc_q;
        count_d   = count_q;
        compare_d = compare_q;
        cp0_write = wb_valid & ~exception_valid & move_to_cp0 & (cp0_address_select == 3'd0);
`ifdef WB_TIMER_INTERRUPT_EN
        tick_d        = ~tick_q;
        compare_write = cp0_write & (cp0_address_register == CP0_COMPARE);
        if (tick_q) begin
            count_d = count_q + 32'd1;
        end
`endif
        if (cp0_write) begin
            case (cp0_address_register)
                CP0_STATUS:  status_d  = (status_q & ~STATUS_WRITE_MASK) | (write_data & STATUS_WRITE_MASK);
                CP0_CAUSE:   cause_d   = (cause_q & ~CAUSE_WRITE_MASK) | (write_data & CAUSE_WRITE_MASK);
                CP0_EPC:     epc_d     = write_data;
                CP0_COUNT:   count_d   = write_data;
                CP0_COMPARE: compare_d = write_data;
                default: ;
            endcase
        end
`ifdef WB_TIMER_INTERRUPT_EN
        // A Compare write in the same cycle as a match acknowledges the timer.
        ti_d = cause_q[CAUSE_TI] | (count_d == compare_d);
        if (compare_write) begin
            ti_d = 1'b0;
        end
        cause_d[CAUSE_TI]            = ti_d;
        cause_d[CAUSE_IP_LO+2 +: 6]  = {hardware_interrupt[5] | ti_d, hardware_interrupt[4:0]};
`else
        cause_d[CAUSE_TI]            = 1'b0;
        cause_d[CAUSE_IP_LO+2 +: 6]  = hardware_interrupt;
`endif
        if (wb_valid & exception_valid) begin
            // A nested exception keeps the original EPC/BD so the first handler can still return.
            if (!status_q[STATUS_EXL]) begin
                epc_d             = in_delay_slot ? program_count - 32'd4 : program_count;
                cause_d[CAUSE_BD] = in_delay_slot;
            end
            cause_d[CAUSE_EXC_LO +: 5] = exception_code;
            status_d[STATUS_EXL]       = 1'b1;
        end else if (wb_valid & eret_flush) begin
            status_d[STATUS_EXL] = 1'b0;
        end
        interrupt_pending_d = status_q[STATUS_IE] & ~status_q[STATUS_EXL]
                            & (|(cause_q[CAUSE_IP_LO +: 8] & status_q[STATUS_IM_LO +: 8]));
    end

    always_comb begin
        read_data = 32'd0;
        if (cp0_address_select == 3'd0) begin
            case (cp0_address_register)
                CP0_STATUS:  read_data = status_q;
                CP0_CAUSE:   read_data = cause_q;
                CP0_EPC:     read_data = epc_q;
                CP0_COUNT:   read_data = count_q;
                CP0_COMPARE: read_data = compare_q;
                default:     read_data = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            status_q            <= RESET_STATUS;
            cause_q             <= 32'd0;
            epc_q               <= 32'd0;
            count_q             <= 32'd0;
            compare_q           <= 32'd0;
            interrupt_pending_q <= 1'b0;
        end else begin
            status_q            <= status_d;
            cause_q             <= cause_d;
            epc_q               <= epc_d;
            count_q             <= count_d;
            compare_q           <= compare_d;
            interrupt_pending_q <= interrupt_pending_d;
        end
    end

`ifdef WB_TIMER_INTERRUPT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= tick_d;
        end
    end
`endif

    assign epc               = epc_q;
    assign interrupt_pending = interrupt_pending_q;

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - MIPS write-back stage: GPR commit, CP0, exception/ERET broadcast, debug trace.
// Timer interrupt in CP0 is enabled by defining WB_TIMER_INTERRUPT_EN.
module wb_stage
    import io_stage_params::*;
    import wb_stage_params::*;
#(
    parameter logic [31:0] EXCEPTION_ENTRY = 32'hbfc0_0380,
    parameter logic [31:0] RESET_STATUS    = 32'h0040_0000
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic              wb_allow_in,
    input  IOToWBData         io_to_wb_bus,
    output WBExceptionBus     wb_exception_bus,
    output WBToIDBackPassData wb_to_id_back_pass_bus,
    output logic [3:0]        register_file_write_strobe,
    output logic [4:0]        register_file_write_address,
    output logic [31:0]       register_file_write_data,
    input  logic [5:0]        hardware_interrupt,
    output logic              interrupt_pending,
    output logic [31:0]       debug_wb_program_count,
    output logic [3:0]        debug_wb_rf_wen,
    output logic [4:0]        debug_wb_rf_wnum,
    output logic [31:0]       debug_wb_rf_wdata
);

    IOToWBData   wb_bus_q, wb_bus_d;
    logic        wb_valid;
    logic [3:0]  commit_strobe;
    logic [31:0] commit_data;
    logic [31:0] cp0_read_data;
    logic [31:0] cp0_epc;

    // The payload holds its last value between instructions; only valid drops.
    always_comb begin
        wb_bus_d       = wb_bus_q;
        wb_bus_d.valid = 1'b0;
        if (io_to_wb_bus.valid) begin
            wb_bus_d = io_to_wb_bus;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wb_bus_q <= '0;
        end else begin
            wb_bus_q <= wb_bus_d;
        end
    end

    assign wb_valid = wb_bus_q.valid;

    cp0_register_file #(
        .RESET_STATUS(RESET_STATUS)
    ) u_cp0 (
        .clock                (clock),
        .reset_n              (reset_n),
        .wb_valid             (wb_valid),
        .exception_valid      (wb_bus_q.exception_valid),
        .eret_flush           (wb_bus_q.eret_flush),
        .in_delay_slot        (wb_bus_q.in_delay_slot),
        .exception_code       (wb_bus_q.exception_code),
        .program_count        (wb_bus_q.program_count),
        .move_to_cp0          (wb_bus_q.move_to_cp0),
        .cp0_address_register (wb_bus_q.cp0_address_register),
        .cp0_address_select   (wb_bus_q.cp0_address_select),
        .write_data           (wb_bus_q.final_result),
        .hardware_interrupt   (hardware_interrupt),
        .read_data            (cp0_read_data),
        .epc                  (cp0_epc),
        .interrupt_pending    (interrupt_pending)
    );

    always_comb begin
        commit_strobe = {4{wb_valid & wb_bus_q.register_file_write_enabled & ~wb_bus_q.exception_valid}}
                      & wb_bus_q.register_file_write_strobe;
        commit_data   = wb_bus_q.move_from_cp0 ? cp0_read_data : wb_bus_q.final_result;
    end

    always_comb begin
        wb_exception_bus = '0;
        if (wb_valid & wb_bus_q.exception_valid) begin
            wb_exception_bus.exception_valid = 1'b1;
            wb_exception_bus.target          = EXCEPTION_ENTRY;
        end else if (wb_valid & wb_bus_q.eret_flush) begin
            wb_exception_bus.eret_flush = 1'b1;
            wb_exception_bus.target     = cp0_epc;
        end
    end

    always_comb begin
        wb_to_id_back_pass_bus                = '0;
        wb_to_id_back_pass_bus.valid          = wb_valid;
        wb_to_id_back_pass_bus.write_register = wb_bus_q.register_file_address;
        wb_to_id_back_pass_bus.write_strobe   = commit_strobe;
        wb_to_id_back_pass_bus.write_data     = commit_data;
    end

    assign wb_allow_in                 = 1'b1;
    assign register_file_write_strobe  = commit_strobe;
    assign register_file_write_address = wb_bus_q.register_file_address;
    assign register_file_write_data    = commit_data;
    assign debug_wb_program_count      = wb_bus_q.program_count;
    assign debug_wb_rf_wen             = commit_strobe;
    assign debug_wb_rf_wnum            = wb_bus_q.register_file_address;
    assign debug_wb_rf_wdata           = commit_data;

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - self-checking bench for wb_stage: vector table, scoreboard, CP0 corner sequences.
module tb_wb_stage;
    import io_stage_params::*;
    import wb_stage_params::*;

    localparam logic [31:0] ENTRY = 32'hbfc0_0380;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] result;
        logic [4:0]  dest;
        logic        we;
        logic [3:0]  strb;
        logic [4:0]  cp0r;
        logic [2:0]  sel;
        logic        mfc0;
        logic        mtc0;
        logic        exc;
        logic        ds;
        logic        eret;
        logic [4:0]  code;
        logic        chk;
        logic [3:0]  e_strb;
        logic [31:0] e_data;
        logic        e_exc;
        logic        e_eret;
        logic [31:0] e_tgt;
    } vec_t;

    logic              clock;
    logic              reset_n;
    logic              wb_allow_in;
    IOToWBData         io_bus;
    WBExceptionBus     exc_bus;
    WBToIDBackPassData bp_bus;
    logic [3:0]        rf_strobe;
    logic [4:0]        rf_addr;
    logic [31:0]       rf_data;
    logic [5:0]        hw_int;
    logic              interrupt_pending;
    logic [31:0]       dbg_pc;
    logic [3:0]        dbg_wen;
    logic [4:0]        dbg_wnum;
    logic [31:0]       dbg_wdata;

    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t exp_q[$];
    vec_t tbl[$];

    wb_stage dut (
        .clock                       (clock),
        .reset_n                     (reset_n),
        .wb_allow_in                 (wb_allow_in),
        .io_to_wb_bus                (io_bus),
        .wb_exception_bus            (exc_bus),
        .wb_to_id_back_pass_bus      (bp_bus),
        .register_file_write_strobe  (rf_strobe),
        .register_file_write_address (rf_addr),
        .register_file_write_data    (rf_data),
        .hardware_interrupt          (hw_int),
        .interrupt_pending           (interrupt_pending),
        .debug_wb_program_count      (dbg_pc),
        .debug_wb_rf_wen             (dbg_wen),
        .debug_wb_rf_wnum            (dbg_wnum),
        .debug_wb_rf_wdata           (dbg_wdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t v_alu(input logic [31:0] pc, input logic [4:0] dest, input logic [3:0] strb,
                                   input logic we, input logic [31:0] res, input logic [3:0] e_strb);
        vec_t v = '0;
        v.valid = 1'b1; v.pc = pc; v.dest = dest; v.strb = strb; v.we = we; v.result = res;
        v.chk = 1'b1; v.e_strb = e_strb; v.e_data = res;
        return v;
    endfunction

    function automatic vec_t v_mfc(input logic [4:0] r, input logic [2:0] sel, input logic [31:0] exp);
        vec_t v = '0;
        v.valid = 1'b1; v.pc = 32'hbfc0_1000; v.dest = 5'd8; v.we = 1'b1; v.strb = 4'hf;
        v.mfc0 = 1'b1; v.cp0r = r; v.sel = sel; v.result = 32'hdead_beef;
        v.chk = 1'b1; v.e_strb = 4'hf; v.e_data = exp;
        return v;
    endfunction

    function automatic vec_t v_mtc(input logic [4:0] r, input logic [31:0] data);
        vec_t v = '0;
        v.valid = 1'b1; v.pc = 32'hbfc0_2000; v.mtc0 = 1'b1; v.cp0r = r; v.result = data;
        v.strb = 4'hf;
        return v;
    endfunction

    function automatic vec_t v_exc(input logic [31:0] pc, input logic [4:0] code, input logic ds);
        vec_t v = '0;
        v.valid = 1'b1; v.pc = pc; v.exc = 1'b1; v.code = code; v.ds = ds;
        v.we = 1'b1; v.strb = 4'hf; v.dest = 5'd3; v.result = 32'h0bad_0bad;
        v.e_exc = 1'b1; v.e_tgt = ENTRY;
        return v;
    endfunction

    function automatic vec_t v_eret(input logic [31:0] tgt);
        vec_t v = '0;
        v.valid = 1'b1; v.pc = 32'hbfc0_3000; v.eret = 1'b1;
        v.e_eret = 1'b1; v.e_tgt = tgt;
        return v;
    endfunction

    function automatic vec_t v_idle();
        vec_t v = '0;
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        vec_t e;
        @(negedge clock);
        io_bus                             = '0;
        io_bus.valid                       = v.valid;
        io_bus.program_count               = v.pc;
        io_bus.final_result                = v.result;
        io_bus.register_file_address       = v.dest;
        io_bus.register_file_write_enabled = v.we;
        io_bus.register_file_write_strobe  = v.strb;
        io_bus.cp0_address_register        = v.cp0r;
        io_bus.cp0_address_select          = v.sel;
        io_bus.move_from_cp0               = v.mfc0;
        io_bus.move_to_cp0                 = v.mtc0;
        io_bus.exception_valid             = v.exc;
        io_bus.in_delay_slot               = v.ds;
        io_bus.eret_flush                  = v.eret;
        io_bus.exception_code              = v.code;
        exp_q.push_back(v);
        @(posedge clock);
        #1;
        io_bus.valid = 1'b0;
        e = exp_q.pop_front();
        chk("rf_strobe", {28'd0, rf_strobe}, {28'd0, e.e_strb});
        chk("exc_valid", {31'd0, exc_bus.exception_valid}, {31'd0, e.e_exc});
        chk("eret_flush", {31'd0, exc_bus.eret_flush}, {31'd0, e.e_eret});
        chk("exc_target", exc_bus.target, e.e_tgt);
        if (e.chk) begin
            chk("rf_addr", {27'd0, rf_addr}, {27'd0, e.dest});
            chk("rf_data", rf_data, e.e_data);
            chk("dbg_pc", dbg_pc, e.pc);
            chk("dbg_wen", {28'd0, dbg_wen}, {28'd0, e.e_strb});
            chk("dbg_wnum", {27'd0, dbg_wnum}, {27'd0, e.dest});
            chk("dbg_wdata", dbg_wdata, e.e_data);
            chk("bp_valid", {31'd0, bp_bus.valid}, 32'd1);
            chk("bp_data", bp_bus.write_data, e.e_data);
        end
    endtask

    initial begin
        vec_t v;
        logic found;

        tbl.push_back(v_alu(32'hbfc0_0100, 5'd5, 4'b1111, 1'b1, 32'h1234_5678, 4'b1111));
        tbl.push_back(v_alu(32'hbfc0_0104, 5'd7, 4'b0011, 1'b1, 32'haabb_ccdd, 4'b0011));
        tbl.push_back(v_alu(32'hbfc0_0108, 5'd9, 4'b1111, 1'b0, 32'h1111_1111, 4'b0000));
        tbl.push_back(v_alu(32'hbfc0_010c, 5'd0, 4'b1111, 1'b1, 32'h55aa_55aa, 4'b1111));
        tbl.push_back(v_mtc(CP0_COMPARE, 32'hcafe_f00d));
        tbl.push_back(v_mfc(CP0_COMPARE, 3'd0, 32'hcafe_f00d));
        tbl.push_back(v_mfc(CP0_STATUS, 3'd0, 32'h0040_0000));
        tbl.push_back(v_mfc(CP0_CAUSE, 3'd0, 32'h0000_0000));
        tbl.push_back(v_mfc(CP0_STATUS, 3'd1, 32'h0000_0000));
        tbl.push_back(v_mfc(5'd3, 3'd0, 32'h0000_0000));
        tbl.push_back(v_mtc(CP0_STATUS, 32'hffff_fffc));
        tbl.push_back(v_mfc(CP0_STATUS, 3'd0, 32'h0040_ff00));
        tbl.push_back(v_mtc(CP0_EPC, 32'h8000_1000));
        tbl.push_back(v_mfc(CP0_EPC, 3'd0, 32'h8000_1000));
        tbl.push_back(v_mtc(CP0_CAUSE, 32'hffff_ffff));
        tbl.push_back(v_mfc(CP0_CAUSE, 3'd0, 32'h0000_0300));
        tbl.push_back(v_mtc(CP0_CAUSE, 32'h0000_0000));
        tbl.push_back(v_exc(32'hbfc0_0204, EXC_SYS, 1'b1));
        tbl.push_back(v_idle());
        tbl.push_back(v_mfc(CP0_EPC, 3'd0, 32'hbfc0_0200));
        tbl.push_back(v_mfc(CP0_CAUSE, 3'd0, 32'h8000_0020));
        tbl.push_back(v_mfc(CP0_STATUS, 3'd0, 32'h0040_ff02));
        tbl.push_back(v_exc(32'hbfc0_0300, EXC_OV, 1'b0));
        tbl.push_back(v_mfc(CP0_EPC, 3'd0, 32'hbfc0_0200));
        tbl.push_back(v_mfc(CP0_CAUSE, 3'd0, 32'h8000_0030));
        tbl.push_back(v_mtc(CP0_EPC, 32'h8000_1000));
        tbl.push_back(v_eret(32'h8000_1000));
        tbl.push_back(v_idle());
        tbl.push_back(v_mfc(CP0_STATUS, 3'd0, 32'h0040_ff00));
        v = v_exc(32'h8000_2000, EXC_ADEL, 1'b0);
        v.eret = 1'b1;
        tbl.push_back(v);
        tbl.push_back(v_mfc(CP0_EPC, 3'd0, 32'h8000_2000));
        tbl.push_back(v_mfc(CP0_CAUSE, 3'd0, 32'h0000_0010));
        tbl.push_back(v_eret(32'h8000_2000));
        tbl.push_back(v_mfc(CP0_STATUS, 3'd0, 32'h0040_ff00));

        io_bus  = '0;
        hw_int  = 6'd0;
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_strobe", {28'd0, rf_strobe}, 32'd0);
        chk("reset_exc_bus", {exc_bus.exception_valid, exc_bus.eret_flush, exc_bus.target[29:0]}, 32'd0);
        chk("reset_irq_pending", {31'd0, interrupt_pending}, 32'd0);
        chk("allow_in", {31'd0, wb_allow_in}, 32'd1);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            run_vec(tbl[i]);
        end

        // Interrupt gating by IE/IM, then masked by EXL.
        hw_int = 6'b000001;
        run_vec(v_mtc(CP0_STATUS, 32'h0000_0401));
        for (int i = 0; i < 4 && !interrupt_pending; i++) @(negedge clock);
        chk("irq_pending_set", {31'd0, interrupt_pending}, 32'd1);
        run_vec(v_exc(32'hbfc0_0400, EXC_INT, 1'b0));
        for (int i = 0; i < 3 && interrupt_pending; i++) @(negedge clock);
        chk("irq_pending_exl", {31'd0, interrupt_pending}, 32'd0);
        hw_int = 6'd0;
        run_vec(v_eret(32'hbfc0_0400));
        run_vec(v_mfc(CP0_STATUS, 3'd0, 32'h0040_0401));

`ifdef WB_TIMER_INTERRUPT_EN
        run_vec(v_mtc(CP0_COUNT, 32'd0));
        run_vec(v_mtc(CP0_COMPARE, 32'd3));
        found = 1'b0;
        for (int i = 0; i < 16 && !found; i++) begin
            v = v_mfc(CP0_CAUSE, 3'd0, 32'd0);
            v.chk = 1'b0;
            run_vec(v);
            found = rf_data[30];
        end
        chk("timer_ti_set", {31'd0, found}, 32'd1);
        run_vec(v_mtc(CP0_COMPARE, 32'h0000_0100));
        v = v_mfc(CP0_CAUSE, 3'd0, 32'd0);
        v.chk = 1'b0;
        run_vec(v);
        chk("timer_ti_clear", {31'd0, rf_data[30]}, 32'd0);
`else
        found = 1'b0;
`endif

        // Reset asserted while an instruction is committing.
        @(negedge clock);
        io_bus                             = '0;
        io_bus.valid                       = 1'b1;
        io_bus.program_count               = 32'hbfc0_0500;
        io_bus.final_result                = 32'hfeed_face;
        io_bus.register_file_address       = 5'd12;
        io_bus.register_file_write_enabled = 1'b1;
        io_bus.register_file_write_strobe  = 4'hf;
        @(posedge clock);
        #1;
        io_bus.valid = 1'b0;
        chk("pre_reset_strobe", {28'd0, rf_strobe}, 32'h0000_000f);
        reset_n = 1'b0;
        #1;
        chk("midreset_strobe", {28'd0, rf_strobe}, 32'd0);
        chk("midreset_data", rf_data, 32'd0);
        chk("midreset_pc", dbg_pc, 32'd0);
        chk("midreset_bp_valid", {31'd0, bp_bus.valid}, 32'd0);
        chk("midreset_irq", {31'd0, interrupt_pending}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        run_vec(v_mfc(CP0_STATUS, 3'd0, 32'h0040_0000));
        run_vec(v_alu(32'hbfc0_0600, 5'd31, 4'b1100, 1'b1, 32'h0f0f_0f0f, 4'b1100));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back stage of the 5-stage MIPS core; consumes the IO stage's `io_to_wb_bus` and commits results to the GPR file with a per-byte strobe.
- Owns the CP0 register set: Status, Cause, EPC, Count, Compare.
- Retires exceptions and ERET, and broadcasts flush/target on `wb_exception_bus` to all upstream stages.
- Drives the debug trace ports and the interrupt-pending flag sampled by ID.

Parameters:
- EXCEPTION_ENTRY, 32'hbfc0_0380, fetch target on exception retire.
- RESET_STATUS, 32'h0040_0000, Status reset value (BEV=1, EXL=0, IE=0, IM=0).

Ports:
- clock  in  1  core clock.
- reset_n  in  1  asynchronous, active-low reset.
- wb_allow_in  out  1  constant 1; WB never stalls.
- io_to_wb_bus  in  io_stage_params::IOToWBData  fields: valid, program_count, final_result, register_file_address, register_file_write_enabled, register_file_write_strobe, cp0_address_register, cp0_address_select, move_from_cp0, move_to_cp0, exception_valid, in_delay_slot, eret_flush, exception_code.
- wb_exception_bus  out  wb_stage_params::WBExceptionBus  {exception_valid, eret_flush, target[31:0]}.
- wb_to_id_back_pass_bus  out  wb_stage_params::WBToIDBackPassData  {valid, write_register, write_strobe, write_data}, for bypass.
- register_file_write_strobe  out  4  byte write enables to the GPR file.
- register_file_write_address  out  5  GPR index.
- register_file_write_data  out  32  GPR data.
- hardware_interrupt  in  6  external interrupt lines, level-sensitive.
- interrupt_pending  out  1  to ID: tag the next instruction with the interrupt exception.
- debug_wb_program_count  out  32  trace PC.
- debug_wb_rf_wen  out  4  trace write strobe.
- debug_wb_rf_wnum  out  5  trace register number.
- debug_wb_rf_wdata  out  32  trace data.

Behaviour:
- **Pipeline register.** `wb_valid` and the bus are captured every edge when `io_to_wb_bus.valid`; `wb_valid <= io_to_wb_bus.valid`. The instruction commits during the following cycle; CP0 and GPR are updated at the next edge. Total latency is 1 cycle.
- **Reset values.** While `reset_n`=0: `wb_valid`=0, all strobes 0, exception bus all 0, Status=RESET_STATUS, Cause=0, EPC=0, Count=0, Compare=0, tick=0, `interrupt_pending`=0.
- **GPR write.**
  - strobe = {4{wb_valid & write_enabled & ~exception_valid}} & bus strobe.
  - Writes to register 0 are issued as-is; the register file ignores them.
  - data = move_from_cp0 ? CP0 read value : final_result.
  - Unimplemented CP0 addresses, or any select≠0, read 0.
- **mtc0.** Applies only when `wb_valid & ~exception_valid`.
  - Status writes IM[15:8], EXL[1], IE[0]; other bits are read-only.
  - Cause writes IP[9:8] only.
  - EPC and Count write the full word.
  - Compare writes the full word and clears Cause.TI.
- **Exception retire** (`wb_valid & exception_valid`):
  - wb_exception_bus.exception_valid=1, target=EXCEPTION_ENTRY.
  - If Status.EXL=0: EPC <= in_delay_slot ? pc-4 : pc, and Cause.BD <= in_delay_slot.
  - Always: Cause.ExcCode <= exception_code, Status.EXL <= 1.
  - GPR and mtc0 writes are suppressed.
- **ERET** (`wb_valid & eret_flush`, and no exception): eret_flush=1, target=EPC (pre-update value), Status.EXL <= 0.
- The exception bus is combinational from the WB registers; it is high for exactly one cycle per event. When exception and eret are both set, exception wins.
- **Interrupts.**
  - Cause.IP[7:2] <= hardware_interrupt each cycle (registered). IP[7] is ORed with Cause.TI when the timer is built in.
  - interrupt_pending = Status.IE & ~Status.EXL & |(Cause.IP[7:0] & Status.IM[7:0]); registered.

Optional Feature:
- Macro `WB_TIMER_INTERRUPT_EN`.
- When defined:
  - A 1-bit tick toggles every cycle; Count increments when tick=1, i.e. every 2 cycles, wrapping at 2^32.
  - An mtc0 to Count in the same cycle overrides the increment.
  - Count==Compare (after the update) sets Cause.TI. An mtc0 to Compare in the same cycle wins and clears TI.
- When undefined: Count and Compare are plain read/write registers, TI stays 0, and IP[7] = hardware_interrupt[5] only.

Decomposition:
- Package `wb_stage_params` holds:
  - the WBExceptionBus and WBToIDBackPassData structs;
  - a Cp0Register enum (Count=9, Compare=11, Status=12, Cause=13, EPC=14);
  - ExcCode constants (Int=0, AdEL=4, AdES=5, Sys=8, Bp=9, RI=10, Ov=12);
  - Status/Cause bit-position localparams.
- One sub-module, `cp0_register_file`: CP0 registers, mtc0 decode, timer, and exception/eret updates. It outputs the read data, EPC, and interrupt_pending.

Test Plan:
1. **Plain ALU write.** pc=0xbfc0_0100, dest=5, strobe=4'b1111, result=0x1234_5678 → next cycle rf strobe 1111, addr 5, data 0x1234_5678; debug ports match.
2. **Exception in delay slot.** Syscall, exception_code=8, in_delay_slot=1, pc=0xbfc0_0204, EXL=0 → one-cycle exception_valid, target 0xbfc0_0380; EPC=0xbfc0_0200, BD=1, ExcCode=8, EXL=1; rf strobe 0.
3. **Nested exception.** Second exception while EXL=1 → EPC unchanged; ExcCode updated.
4. **ERET.** mtc0 EPC=0x8000_1000, then eret → eret_flush=1 for one cycle, target 0x8000_1000, EXL=0.
5. **Interrupt gating.** Status=0x0000_0401 (IM2, IE), hardware_interrupt=6'b000001 → interrupt_pending=1 within 2 cycles; with EXL=1 → 0.
6. **Timer** (`WB_TIMER_INTERRUPT_EN`). mtc0 Count=0, Compare=3 → TI=1 after 6–7 cycles; mtc0 Compare → TI=0. Also assert `reset_n` low mid-commit → all outputs 0 immediately.
